rf_write_arbiter: RTL

Shares the single write port of the pipeline's 32×32 register file among three writers: the writeback stage, the multi-cycle multiply/divide unit (MDU) and the debug loader. It sits between those sources and the register file's RegWrite/Write_register/Write_data inputs. It also keeps a busy scoreboard of MDU destinations so the hazard unit can stall dependent reads. It guarantees MDU forward progress by stalling writeback for one cycle when the MDU has waited too long.

---
 rtl/rf_write_arbiter.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: shares the register-file write port among writeback,
// the multiply/divide unit and the debug loader. It also tracks which
// registers have an MDU result outstanding so the hazard unit can stall
// dependent reads, and it briefly stalls writeback so a waiting MDU
// write always completes.
module rf_write_arbiter #(
  parameter int STARVE_LIMIT = 4,   // 1..15 blocked cycles before a writeback stall
  parameter int DATA_W       = 32
) (
  input  logic              clk,
  input  logic              reset,        // asynchronous, active-low

  // writeback stage (no handshake; re-presents while wb_stall is high)
  input  logic              wb_we,
  input  logic [4:0]        wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              wb_stall,

  // multiply/divide unit (held until acked)
  input  logic              mdu_req,
  input  logic [4:0]        mdu_addr,
  input  logic [DATA_W-1:0] mdu_data,
  output logic              mdu_ack,

  // debug loader (held until acked)
  input  logic              dbg_req,
  input  logic [4:0]        dbg_addr,
  input  logic [DATA_W-1:0] dbg_data,
  output logic              dbg_ack,

  // MDU issue marks the destination register busy
  input  logic              mdu_issue,
  input  logic [4:0]        mdu_issue_addr,

  // hazard-unit queries
  input  logic [4:0]        rs_addr,
  input  logic [4:0]        rt_addr,
  output logic              rs_busy,
  output logic              rt_busy,

  output logic              err_waw,

  // register-file write port
  output logic              rf_we,
  output logic [4:0]        rf_waddr,
  output logic [DATA_W-1:0] rf_wdata
);

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } state_e;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_e      state_q, state_d;
  logic [3:0]  wait_cnt_q, wait_cnt_d;
  logic [31:0] busy_q, busy_d;        // bit 0 is never set
  logic        err_waw_q, err_waw_d;

  logic        wb_win, mdu_win, dbg_win;
  logic        mdu_blocked;

  // Grant selection; nothing is granted while reset is held so the write
  // port and acks stay quiet even if sources keep requesting.
  always_comb begin
    wb_win  = reset && wb_we && (state_q == RUN);
    mdu_win = reset && !wb_win && mdu_req;
    dbg_win = reset && !wb_win && !mdu_req && dbg_req;
  end

  assign mdu_blocked = mdu_req && !mdu_win;
  assign mdu_ack     = mdu_win;
  assign dbg_ack     = dbg_win;
  assign wb_stall    = (state_q == STALL);

  // Drive the register-file port from the winner; address 0 is acked but never written.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned, which would infer a latch.
    rf_we    = 1'b0;
    rf_waddr = '0;
    rf_wdata = '0;
    if (wb_win) begin
      rf_we    = (wb_addr != 5'd0);
      rf_waddr = wb_addr;
      rf_wdata = wb_data;
    end else if (mdu_win) begin
      rf_we    = (mdu_addr != 5'd0);
      rf_waddr = mdu_addr;
      rf_wdata = mdu_data;
    end else if (dbg_win) begin
      rf_we    = (dbg_addr != 5'd0);
      rf_waddr = dbg_addr;
      rf_wdata = dbg_data;
    end
  end

  // Starvation FSM: one STALL cycle once the MDU has been blocked LIMIT cycles in a row.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      RUN: begin
        if (mdu_blocked) begin
          if (wait_cnt_q + 4'd1 == LIMIT) begin
            state_d    = STALL;
            wait_cnt_d = '0;
          end else begin
            wait_cnt_d = wait_cnt_q + 4'd1;
          end
        end else begin
          wait_cnt_d = '0;
        end
      end
      STALL: begin
        // The MDU is either granted here or not requesting, so the count restarts.
        state_d    = RUN;
        wait_cnt_d = '0;
      end
      default: begin
        state_d    = RUN;
        wait_cnt_d = '0;
      end
    endcase
  end

  // Busy scoreboard and sticky write-after-write error; an issue beats a same-address retire.
  always_comb begin
    busy_d = busy_q;
    if (mdu_win) busy_d[mdu_addr] = 1'b0;
    if (mdu_issue) busy_d[mdu_issue_addr] = 1'b1;
    busy_d[0] = 1'b0;

    err_waw_d = err_waw_q;
    if (wb_win && (wb_addr != 5'd0) && busy_q[wb_addr]) err_waw_d = 1'b1;
  end

  assign rs_busy = busy_q[rs_addr];
  assign rt_busy = busy_q[rt_addr];
  assign err_waw = err_waw_q;

  // State registers, all cleared by the asynchronous reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
      busy_q     <= '0;
      err_waw_q  <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      busy_q     <= busy_d;
      err_waw_q  <= err_waw_d;
    end
  end

endmodule
